// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the board LED arbiter/sequencer.
// Mode codes, FSM states and small decode helpers.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SOLID = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam logic [4:0] BURST_ZERO_LEN = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OFF_HOLD,
        ST_SOLID,
        ST_BLINK_ON,
        ST_BLINK_OFF,
        ST_BURST_ON,
        ST_BURST_OFF,
        ST_BURST_DONE
    } state_e;

    function automatic state_e entry_state(input logic [1:0] m);
        state_e s;
        unique case (m)
            MODE_SOLID: s = ST_SOLID;
            MODE_BLINK: s = ST_BLINK_ON;
            MODE_BURST: s = ST_BURST_ON;
            default:    s = ST_OFF_HOLD;
        endcase
        return s;
    endfunction

    function automatic logic led_of(input state_e s);
        return (s == ST_SOLID) || (s == ST_BLINK_ON) || (s == ST_BURST_ON);
    endfunction

endpackage

// File: rtl/led_blink_ctrl_tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every DIV cycles.
// clr restarts the count so the next tick lands exactly DIV cycles later.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// Fixed-priority LED arbiter: grants one shared LED to the lowest-index
// requester and plays its OFF/SOLID/BLINK/BURST pattern on a tick base.
module led_blink_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int NUM_REQ  = 4,
    parameter int HP_W     = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] mode,
    input  logic [HP_W-1:0]      half_period,
    input  logic [3:0]           burst_len,
    output logic                 led,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [NUM_REQ-1:0]   done
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               led_q, led_d;
    logic [HP_W-1:0]    hp_q, hp_d;
    logic [4:0]         len_q, len_d;
    logic [HP_W-1:0]    phase_q, phase_d;
    logic [4:0]         pulse_q, pulse_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic               found;
    logic [1:0]         win_mode;
    logic               regrant;
    logic               tick;
    logic               phase_last;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !found) begin
                found      = 1'b1;
                win_oh[i]  = 1'b1;
                win_idx    = IW'(i);
            end
        end
    end

    assign win_mode   = mode[{win_idx, 1'b0} +: 2];
    assign regrant    = (win_oh != grant_q);
    assign phase_last = (phase_q == hp_q - HP_W'(1));

    tick_prescaler #(.DIV(TICK_DIV)) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (regrant),
        .tick    (tick)
    );

    always_comb begin
        grant_d = grant_q;
        state_d = state_q;
        hp_d    = hp_q;
        len_d   = len_q;
        phase_d = phase_q;
        pulse_d = pulse_q;
        if (regrant) begin
            grant_d = win_oh;
            hp_d    = (half_period == '0) ? HP_W'(1) : half_period;
            len_d   = (burst_len == 4'd0) ? BURST_ZERO_LEN : {1'b0, burst_len};
            phase_d = '0;
            pulse_d = '0;
            state_d = found ? entry_state(win_mode) : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_BLINK_ON, ST_BLINK_OFF, ST_BURST_ON: begin
                    if (tick) begin
                        phase_d = phase_last ? '0 : phase_q + HP_W'(1);
                        if (phase_last) begin
                            unique case (state_q)
                                ST_BLINK_ON:  state_d = ST_BLINK_OFF;
                                ST_BLINK_OFF: state_d = ST_BLINK_ON;
                                default:      state_d = ST_BURST_OFF;
                            endcase
                        end
                    end
                end
                ST_BURST_OFF: begin
                    if (tick) begin
                        phase_d = phase_last ? '0 : phase_q + HP_W'(1);
                        if (phase_last) begin
                            if (pulse_q == len_q - 5'd1) begin
                                state_d = ST_BURST_DONE;
                            end else begin
                                pulse_d = pulse_q + 5'd1;
                                state_d = ST_BURST_ON;
                            end
                        end
                    end
                end
                ST_BURST_DONE: state_d = ST_OFF_HOLD;
                default: ;
            endcase
        end
    end

    // Outputs are registered from next state so req-to-LED latency is one cycle.
    assign led_d  = led_of(state_d);
    assign done_d = (state_d == ST_BURST_DONE) ? grant_d : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            led_q   <= 1'b0;
            hp_q    <= HP_W'(1);
            len_q   <= BURST_ZERO_LEN;
            phase_q <= '0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            led_q   <= led_d;
            hp_q    <= hp_d;
            len_q   <= len_d;
            phase_q <= phase_d;
            pulse_q <= pulse_d;
        end
    end

    assign led   = led_q;
    assign grant = grant_q;
    assign busy  = |grant_q;
    assign done  = done_q;

endmodule
